bcd2bin_seq: RTL

- Sequential BCD-to-binary converter; the inverse of the 4-bit binary-to-BCD decoder (`deco`).
- Accepts a packed N-digit BCD word over a valid/ready handshake.
- Converts it by reverse double-dabble: one shift per clock, with a subtract-3 correction on each digit.
- Returns the binary value over a second valid/ready handshake. Used to bring BCD display/keypad values back into binary arithmetic paths.

---
 rtl/bcd_pkg.sv | 31 +++
 rtl/bcd_digit_adj.sv | 13 +
 rtl/bcd2bin_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the sequential BCD-to-binary converter.
//   state_e         converter FSM states
//   BCD_DIGIT_MAX   largest legal BCD digit value
//   BCD_ADJ_TH/SUB  reverse double-dabble correction threshold and amount
//   bin_width()     minimum binary width that holds 10^n_digits - 1
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ_TH    = 4'd8;
  localparam logic [3:0] BCD_ADJ_SUB   = 4'd3;

  // ceil(log2(10^n_digits)): smallest w with 2^w >= 10^n_digits
  function automatic int bin_width(input int n_digits);
    int p;
    int w;
    p = 1;
    for (int i = 0; i < n_digits; i++) p = p * 10;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < p) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one-digit correction for reverse double-dabble.
//   din   4-bit digit after the right shift
//   dout  din - 3 when din >= 8, else din (never underflows)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= BCD_ADJ_TH) ? (din - BCD_ADJ_SUB) : din;

endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter (reverse double-dabble).
//   clk, rst_n            system clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake for the packed BCD word bcd_in
//   bcd_in                N_DIGITS packed BCD digits, units digit in [3:0]
//   out_valid/out_ready   output handshake for bin_out/err
//   bin_out               binary result (0 when err)
//   err                   some input digit was greater than 9
//
// state | meaning
// IDLE  | ready for a word; validates digits on accept
// CONV  | one shift + digit correction per cycle, BIN_W cycles
// DONE  | result presented until out_ready
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 2,
  parameter int BIN_W    = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  generate
    if (N_DIGITS < 1 || N_DIGITS > 4) begin : g_bad_digits
      $error("bcd2bin_seq: N_DIGITS must be in 1..4");
    end
    if (BIN_W < bin_width(N_DIGITS)) begin : g_bad_width
      $error("bcd2bin_seq: BIN_W too small for N_DIGITS");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [BCD_W-1:0]   bcd_sh;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BIN_W-1:0]   bin_sh;
  logic               in_bad;

  // Shift the whole {bcd, bin} pair right; the LSB of the BCD field
  // falls into the MSB of the binary field.
  assign {bcd_sh, bin_sh} = {bcd_q, bin_q} >> 1;

  generate
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (bcd_sh[4*g +: 4]),
        .dout (bcd_adj[4*g +: 4])
      );
    end
  endgenerate

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > BCD_DIGIT_MAX) in_bad = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          bin_d = '0;
          if (in_bad) begin
            err_d   = 1'b1;
            bcd_d   = '0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            bcd_d   = bcd_in;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        bcd_d = bcd_adj;
        bin_d = bin_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  // bin_q holds partial sums while converting; only expose a finished value
  assign bin_out   = out_valid ? bin_q : '0;
  assign err       = out_valid & err_q;

endmodule
